// File: rtl/video_pkg.sv
// Shared types and defaults for the pixel-domain video output path.
package video_pkg;

  typedef enum logic [1:0] {
    VM_PASS,
    VM_BARS,
    VM_CHECK,
    VM_SOLID
  } vmode_t;

  localparam int COLOR_W_DEF  = 4;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

  function automatic logic [2:0] bar_index(
    input logic [9:0] x,
    input int         bar_w
  );
    int idx;
    idx = int'(x) / bar_w;
    return (idx > 7) ? 3'd7 : idx[2:0];
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with async active-low clear.
// DEPTH of zero degenerates to a wire.
module sync_delay_line
  import video_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_sr
    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/video_out_stage.sv
// Pixel output stage: colour select, blanking, test patterns, frame tick.
// Define VIDEO_OUT_BORDER_EN to force a white border on the active area.
module video_out_stage
  import video_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int PIPE_STAGES = 2,
  parameter int CHK_LOG2    = 4,
  parameter int COLOR_W     = COLOR_W_DEF
) (
  input  logic                 pixel_clk,
  input  logic                 reset_n,
  input  logic [9:0]           draw_x,
  input  logic [9:0]           draw_y,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic                 vde_in,
  input  logic [COLOR_W-1:0]   red_in,
  input  logic [COLOR_W-1:0]   green_in,
  input  logic [COLOR_W-1:0]   blue_in,
  input  logic [1:0]           mode_req,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 vde,
  output logic                 frame_tick,
  output logic [15:0]          frame_count,
  output logic [1:0]           mode_active
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4 ||
      H_ACTIVE < 8 || V_ACTIVE < 2) begin : g_bad_cfg
    $error("video_out_stage: illegal parameters");
  end

  // Syncs travel as active-high so a cleared pipeline reads as idle.
  typedef struct packed {
    logic               tick;
    logic               hs_act;
    logic               vs_act;
    logic               vde;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [COLOR_W-1:0] ONES = '1;

  pix_t        s0_d, s0_q, pipe_out;
  logic        seen_q;
  vmode_t      mode_q;
  logic [15:0] frame_count_q;
  logic [2:0]  bar;
  logic        chk;

  always_comb begin
    bar = bar_index(draw_x, BAR_W);
    chk = 1'((draw_x ^ draw_y) >> CHK_LOG2);

    s0_d        = '0;
    s0_d.tick   = seen_q & ~s0_q.vs_act & ~vs_in;
    s0_d.hs_act = ~hs_in;
    s0_d.vs_act = ~vs_in;
    s0_d.vde    = vde_in;

    if (vde_in) begin
      unique case (1'b1)
        mode_q == VM_PASS: begin
          s0_d.r = red_in;
          s0_d.g = green_in;
          s0_d.b = blue_in;
        end
        mode_q == VM_BARS: begin
          s0_d.r = bar[1] ? '0 : ONES;
          s0_d.g = bar[2] ? '0 : ONES;
          s0_d.b = bar[0] ? '0 : ONES;
        end
        mode_q == VM_CHECK: begin
          s0_d.r = chk ? ONES : '0;
          s0_d.g = chk ? ONES : '0;
          s0_d.b = chk ? ONES : '0;
        end
        mode_q == VM_SOLID: begin
          {s0_d.r, s0_d.g, s0_d.b} = solid_rgb;
        end
        default: ;
      endcase
`ifdef VIDEO_OUT_BORDER_EN
      if (draw_x == 10'(0) || draw_x == 10'(H_ACTIVE-1) ||
          draw_y == 10'(0) || draw_y == 10'(V_ACTIVE-1)) begin
        s0_d.r = ONES;
        s0_d.g = ONES;
        s0_d.b = ONES;
      end
`endif
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_q          <= '0;
      seen_q        <= 1'b0;
      mode_q        <= VM_PASS;
      frame_count_q <= '0;
    end else begin
      s0_q   <= s0_d;
      seen_q <= seen_q | vs_in;
      if (pipe_out.tick) begin
        frame_count_q <= frame_count_q + 16'd1;
        mode_q        <= vmode_t'(mode_req);
      end
    end
  end

  sync_delay_line #(
    .WIDTH ($bits(pix_t)),
    .DEPTH (PIPE_STAGES - 1)
  ) u_delay (
    .clk   (pixel_clk),
    .rst_n (reset_n),
    .d_i   (s0_q),
    .q_o   (pipe_out)
  );

  assign red         = pipe_out.r;
  assign green       = pipe_out.g;
  assign blue        = pipe_out.b;
  assign hsync       = ~pipe_out.hs_act;
  assign vsync       = ~pipe_out.vs_act;
  assign vde         = pipe_out.vde;
  assign frame_tick  = pipe_out.tick;
  assign frame_count = frame_count_q;
  assign mode_active = mode_q;

endmodule
